serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_full_adder.sv | 15 +
 rtl/serial_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the per-bit datapath of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  always_comb begin
    sum_c  = a ^ b ^ cin;
    cout_c = (a & b) | ((a ^ b) & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, IDLE/RUN/DONE handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds the o_overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic bit_sum_c;
  logic bit_cout_c;
  logic accept_c;
  logic last_c;

  full_adder u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry_q),
    .sum_c  (bit_sum_c),
    .cout_c (bit_cout_c)
  );

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_LAST) begin
          last_c    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake flags track the state being entered so they line up with it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      o_ready <= (state_nxt == ST_IDLE);
      o_valid <= (state_nxt == ST_DONE);
    end
  end

  // Operand shifters, carry loop, result shifter and bit counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      o_sum   <= '0;
      o_carry <= 1'b0;
    end else if (accept_c) begin
      a_sh    <= i_a;
      b_sh    <= i_b;
      carry_q <= i_carry;
      cnt     <= '0;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= bit_cout_c;
      o_sum   <= {bit_sum_c, o_sum[WIDTH-1:1]};
      if (last_c) begin
        o_carry <= bit_cout_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (last_c) begin
      o_overflow <= carry_q ^ bit_cout_c;
    end
  end
`endif

endmodule
